// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and baud helper for the multi-byte UART pair
package uart_pkg;

    localparam logic [7:0] PKT_HDR   = 8'h5A;
    localparam int         PKT_LEN   = 8;
    localparam int         DATA_BITS = 8;

    typedef logic [2:0] pkt_state_t;

    localparam pkt_state_t ST_IDLE = 3'd0;
    localparam pkt_state_t ST_LOAD = 3'd1;
    localparam pkt_state_t ST_SEND = 3'd2;
    localparam pkt_state_t ST_WAIT = 3'd3;
    localparam pkt_state_t ST_DONE = 3'd4;

    // Clock cycles per bit, integer-truncated.
    function automatic int calc_bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - single byte UART serializer with start, 8 data bits LSB first and stop bits
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BPS_CNT   = 434,
    parameter int STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       txd
);

    localparam int CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    // Bit slot 0 is the start bit, 1..8 data, the rest stop bits.
    localparam int LAST_BIT = DATA_BITS + STOP_BITS;

    logic             busy;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_W'(BPS_CNT - 1));

    // Done is high during the final cycle of the last stop bit so the packet
    // FSM can issue the next byte with only two idle-high cycles in between.
    assign tx_done = busy && bit_end && (bit_cnt == 4'(LAST_BIT));

    // Baud counter, bit counter, shift register and registered line output.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
        end else if (!busy) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (tx_start) begin
                busy  <= 1'b1;
                shift <= tx_data;
                txd   <= 1'b0;
            end
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'(LAST_BIT)) begin
                busy    <= 1'b0;
                bit_cnt <= '0;
                txd     <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt < 4'(DATA_BITS)) begin
                    txd   <= shift[0];
                    shift <= {1'b0, shift[7:1]};
                end else begin
                    txd <= 1'b1;
                end
            end
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// rtl/uart_mult_byte_tx.sv - 8-byte packet transmitter: header, payload A..D, additive checksum
module uart_mult_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 115200,
    parameter int STOP_BITS = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        send_req,
    input  logic [7:0]  dataA,
    input  logic [15:0] dataB,
    input  logic [15:0] dataC,
    input  logic [7:0]  dataD,
    output logic        send_ack,
    output logic        tx_busy,
    output logic        pack_done,
    output logic [2:0]  byte_idx,
    output logic        uart_txd
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);

    pkt_state_t  state;
    logic [7:0]  lat_a;
    logic [15:0] lat_b;
    logic [15:0] lat_c;
    logic [7:0]  lat_d;
    logic [7:0]  checksum;
    logic [7:0]  cur_byte;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;

    assign checksum = lat_a + lat_b[15:8] + lat_b[7:0] + lat_c[15:8] + lat_c[7:0] + lat_d;

    // Byte multiplexer: picks the packet byte addressed by byte_idx.
    always_comb begin
        cur_byte = PKT_HDR;
        case (byte_idx)
            3'd0: cur_byte = PKT_HDR;
            3'd1: cur_byte = lat_a;
            3'd2: cur_byte = lat_b[15:8];
            3'd3: cur_byte = lat_b[7:0];
            3'd4: cur_byte = lat_c[15:8];
            3'd5: cur_byte = lat_c[7:0];
            3'd6: cur_byte = lat_d;
            3'd7: cur_byte = checksum;
        endcase
    end

    // Packet FSM with payload latch and handshake pulses.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            byte_idx  <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_c     <= '0;
            lat_d     <= '0;
            send_ack  <= 1'b0;
            tx_busy   <= 1'b0;
            pack_done <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            send_ack  <= 1'b0;
            pack_done <= 1'b0;
            tx_start  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (send_req) begin
                        lat_a    <= dataA;
                        lat_b    <= dataB;
                        lat_c    <= dataC;
                        lat_d    <= dataD;
                        send_ack <= 1'b1;
                        tx_busy  <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_start <= 1'b1;
                    tx_data  <= cur_byte;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (byte_idx == 3'(PKT_LEN - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    pack_done <= 1'b1;
                    tx_busy   <= 1'b0;
                    byte_idx  <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_byte_tx #(
        .BPS_CNT   (BPS_CNT),
        .STOP_BITS (STOP_BITS)
    ) u_byte_tx (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .txd      (uart_txd)
    );

endmodule
